// File: rtl/dmarb_pkg.sv
// Shared types and helpers for the data memory arbiter.
//   state_e  : arbitration mode (SHARED / LOCKED / RELEASE)
//   owner_e  : which requester drives the memory port in the current cycle
//   cnt_width: bit width needed to hold a counter value 0..max_val
package dmarb_pkg;

  typedef enum logic [1:0] {
    SHARED,
    LOCKED,
    RELEASE
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CORE,
    OWN_DBG
  } owner_e;

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/dmarb_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, reset : clock, asynchronous active-low reset
//   inc_i      : count up by one (holds at MAX)
//   clr_i      : clear; together with inc_i the counter loads 1, which lets a
//                caller restart a count in the same cycle the event happens
//   cnt_o      : current count
module dmarb_sat_counter #(
  parameter int unsigned    WIDTH = 4,
  parameter logic [WIDTH-1:0] MAX = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = inc_i ? WIDTH'(1) : '0;
    end else if (inc_i && (cnt_q != MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/data_mem_arbiter.sv
// Data memory arbiter: shares the single-port data memory between the
// single-cycle core (fixed priority) and a debug/loader port.
// A wait counter forces a starved debug request through after MAX_WAIT lost
// cycles; a lock mode grants the debug port exclusive bursts of at most
// LOCK_MAX locked cycles, followed by one cycle reserved for the core.
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   core_re_i/we_i/addr_i/wdata_i, core_rdata_o, core_stall_o   core side
//   dbg_valid_i/we_i/lock_i/addr_i/wdata_i, dbg_ready_o,
//   dbg_rvalid_o, dbg_rdata_o                                   debug side
//   mem_re_o/we_o/addr_o/wdata_o, mem_rdata_i                   memory side
// Build option DMARB_STATS_EN: adds saturating counters stat_stall_cnt_o
// (cycles the core was stalled) and stat_dbg_cnt_o (accepted debug requests).
module data_mem_arbiter
  import dmarb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned MAX_WAIT   = 4,
  parameter int unsigned LOCK_MAX   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  core_re_i,
  input  logic                  core_we_i,
  input  logic [ADDR_WIDTH-1:0] core_addr_i,
  input  logic [DATA_WIDTH-1:0] core_wdata_i,
  output logic [DATA_WIDTH-1:0] core_rdata_o,
  output logic                  core_stall_o,
  input  logic                  dbg_valid_i,
  input  logic                  dbg_we_i,
  input  logic                  dbg_lock_i,
  input  logic [ADDR_WIDTH-1:0] dbg_addr_i,
  input  logic [DATA_WIDTH-1:0] dbg_wdata_i,
  output logic                  dbg_ready_o,
  output logic                  dbg_rvalid_o,
  output logic [DATA_WIDTH-1:0] dbg_rdata_o,
  output logic                  mem_re_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
`ifdef DMARB_STATS_EN
  ,
  output logic [31:0]           stat_stall_cnt_o,
  output logic [31:0]           stat_dbg_cnt_o
`endif
);

  localparam int unsigned      WAIT_W     = cnt_width(MAX_WAIT);
  localparam int unsigned      LOCK_W     = cnt_width(LOCK_MAX);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);
  localparam logic [LOCK_W-1:0] LOCK_LIMIT = LOCK_W'(LOCK_MAX);

  state_e                state_q, state_d;
  owner_e                owner;
  logic                  core_req;
  logic                  force_dbg;
  logic                  wait_inc, wait_clr, lock_inc, lock_clr;
  logic [WAIT_W-1:0]     wait_cnt;
  logic [LOCK_W-1:0]     lock_cnt;
  logic                  dbg_rvalid_q, dbg_rvalid_d;
  logic [DATA_WIDTH-1:0] dbg_rdata_q, dbg_rdata_d;

  assign core_req  = core_re_i | core_we_i;
  assign force_dbg = dbg_valid_i && (wait_cnt == WAIT_LIMIT);

  // Owner select and next state. lock_cnt is held at zero outside LOCKED;
  // on lock entry clear+inc loads it with 1 so the entry cycle counts.
  always_comb begin
    state_d  = state_q;
    owner    = OWN_NONE;
    wait_inc = 1'b0;
    wait_clr = 1'b0;
    lock_inc = 1'b0;
    lock_clr = 1'b1;
    case (state_q)
      SHARED: begin
        if (force_dbg) begin
          owner = OWN_DBG;
        end else if (core_req) begin
          owner    = OWN_CORE;
          wait_inc = dbg_valid_i;
        end else if (dbg_valid_i) begin
          owner = OWN_DBG;
        end
        if (owner == OWN_DBG) begin
          wait_clr = 1'b1;
          if (dbg_lock_i) begin
            state_d  = LOCKED;
            lock_inc = 1'b1;
          end
        end
      end
      LOCKED: begin
        lock_clr = 1'b0;
        lock_inc = 1'b1;
        if (dbg_valid_i) owner = OWN_DBG;
        if (!dbg_lock_i || (lock_cnt == LOCK_LIMIT)) state_d = RELEASE;
      end
      RELEASE: begin
        if (core_req) owner = OWN_CORE;
        wait_clr = 1'b1;
        state_d  = SHARED;
      end
      default: state_d = SHARED;
    endcase
  end

  dmarb_sat_counter #(.WIDTH(WAIT_W), .MAX(WAIT_LIMIT)) u_wait_cnt (
    .clk   (clk),
    .reset (reset),
    .inc_i (wait_inc),
    .clr_i (wait_clr),
    .cnt_o (wait_cnt)
  );

  dmarb_sat_counter #(.WIDTH(LOCK_W), .MAX(LOCK_LIMIT)) u_lock_cnt (
    .clk   (clk),
    .reset (reset),
    .inc_i (lock_inc),
    .clr_i (lock_clr),
    .cnt_o (lock_cnt)
  );

  // Memory and readback mux; core_we_i wins over core_re_i.
  always_comb begin
    mem_re_o     = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    core_rdata_o = '0;
    case (owner)
      OWN_CORE: begin
        mem_re_o     = core_re_i & ~core_we_i;
        mem_we_o     = core_we_i;
        mem_addr_o   = core_addr_i;
        mem_wdata_o  = core_wdata_i;
        core_rdata_o = mem_rdata_i;
      end
      OWN_DBG: begin
        mem_re_o    = ~dbg_we_i;
        mem_we_o    = dbg_we_i;
        mem_addr_o  = dbg_addr_i;
        mem_wdata_o = dbg_wdata_i;
      end
      default: ;
    endcase
  end

  assign dbg_ready_o  = (owner == OWN_DBG);
  assign core_stall_o = core_req && (owner != OWN_CORE);

  always_comb begin
    dbg_rvalid_d = dbg_ready_o & ~dbg_we_i;
    dbg_rdata_d  = dbg_rvalid_d ? mem_rdata_i : dbg_rdata_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= SHARED;
      dbg_rvalid_q <= 1'b0;
      dbg_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      dbg_rvalid_q <= dbg_rvalid_d;
      dbg_rdata_q  <= dbg_rdata_d;
    end
  end

  assign dbg_rvalid_o = dbg_rvalid_q;
  assign dbg_rdata_o  = dbg_rdata_q;

`ifdef DMARB_STATS_EN
  dmarb_sat_counter #(.WIDTH(32), .MAX(32'hFFFF_FFFF)) u_stat_stall (
    .clk   (clk),
    .reset (reset),
    .inc_i (core_stall_o),
    .clr_i (1'b0),
    .cnt_o (stat_stall_cnt_o)
  );

  dmarb_sat_counter #(.WIDTH(32), .MAX(32'hFFFF_FFFF)) u_stat_dbg (
    .clk   (clk),
    .reset (reset),
    .inc_i (dbg_ready_o),
    .clr_i (1'b0),
    .cnt_o (stat_dbg_cnt_o)
  );
`endif

endmodule

// File: tb/tb_data_mem_arbiter.sv
module tb_data_mem_arbiter;

  localparam int MAX_WAIT = 4;
  localparam int LOCK_MAX = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        core_re, core_we, dbg_valid, dbg_we, dbg_lock;
  logic [31:0] core_addr, core_wdata, dbg_addr, dbg_wdata;
  logic [31:0] core_rdata_o, dbg_rdata_o, mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic        core_stall_o, dbg_ready_o, dbg_rvalid_o, mem_re_o, mem_we_o;
`ifdef DMARB_STATS_EN
  logic [31:0] stat_stall_cnt_o, stat_dbg_cnt_o;
`endif

  always #5 clk = ~clk;

  data_mem_arbiter #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .MAX_WAIT(MAX_WAIT), .LOCK_MAX(LOCK_MAX)
  ) dut (
    .clk(clk), .reset(reset),
    .core_re_i(core_re), .core_we_i(core_we), .core_addr_i(core_addr),
    .core_wdata_i(core_wdata), .core_rdata_o(core_rdata_o), .core_stall_o(core_stall_o),
    .dbg_valid_i(dbg_valid), .dbg_we_i(dbg_we), .dbg_lock_i(dbg_lock),
    .dbg_addr_i(dbg_addr), .dbg_wdata_i(dbg_wdata), .dbg_ready_o(dbg_ready_o),
    .dbg_rvalid_o(dbg_rvalid_o), .dbg_rdata_o(dbg_rdata_o),
    .mem_re_o(mem_re_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
`ifdef DMARB_STATS_EN
    , .stat_stall_cnt_o(stat_stall_cnt_o), .stat_dbg_cnt_o(stat_dbg_cnt_o)
`endif
  );

  // Behavioural memory: 256 words, combinational read, write on rising edge.
  logic [31:0] mem [256];
  assign mem_rdata_i = mem[mem_addr_o[9:2]];
  always @(posedge clk) if (mem_we_o) mem[mem_addr_o[9:2]] <= mem_wdata_o;

  int chk_cnt  = 0;
  int fail_cnt = 0;

  // Reference model: plain bookkeeping of the arbitration rules.
  bit          m_locked, m_release, m_rvalid;
  int          m_age, m_lost, m_stall_cnt, m_dbg_cnt;
  logic [31:0] m_rdata, e_dbg_word;
  int          e_owner;   // 0 nobody, 1 core, 2 debug
  bit          e_ready, e_stall, e_re, e_we;
  logic [31:0] e_addr, e_wdata, e_core_rdata;

  task automatic set_idle();
    core_re = 0; core_we = 0; core_addr = 0; core_wdata = 0;
    dbg_valid = 0; dbg_we = 0; dbg_lock = 0; dbg_addr = 0; dbg_wdata = 0;
  endtask

  task automatic model_reset();
    m_locked = 0; m_release = 0; m_rvalid = 0; m_rdata = 0;
    m_age = 0; m_lost = 0; m_stall_cnt = 0; m_dbg_cnt = 0;
  endtask

  task automatic model_eval();
    bit creq;
    creq = core_re | core_we;
    e_owner = 0;
    if (m_release) e_owner = creq ? 1 : 0;
    else if (m_locked) e_owner = dbg_valid ? 2 : 0;
    else if (dbg_valid && m_lost >= MAX_WAIT) e_owner = 2;
    else if (creq) e_owner = 1;
    else if (dbg_valid) e_owner = 2;
    e_ready = (e_owner == 2);
    e_stall = creq && (e_owner != 1);
    e_re = (e_owner == 1) ? (core_re && !core_we) : (e_owner == 2) ? !dbg_we : 1'b0;
    e_we = (e_owner == 1) ? core_we : (e_owner == 2) ? dbg_we : 1'b0;
    e_addr  = (e_owner == 1) ? core_addr  : (e_owner == 2) ? dbg_addr  : 32'h0;
    e_wdata = (e_owner == 1) ? core_wdata : (e_owner == 2) ? dbg_wdata : 32'h0;
    e_core_rdata = (e_owner == 1) ? mem[core_addr[9:2]] : 32'h0;
    e_dbg_word = mem[dbg_addr[9:2]];
  endtask

  task automatic model_advance();
    if (e_stall) m_stall_cnt++;
    if (e_ready) m_dbg_cnt++;
    m_rvalid = e_ready && !dbg_we;
    if (m_rvalid) m_rdata = e_dbg_word;
    if (m_release) begin
      m_release = 0;
      m_lost = 0;
    end else if (m_locked) begin
      if (!dbg_lock || m_age == LOCK_MAX) begin
        m_locked = 0;
        m_release = 1;
      end
      m_age++;
    end else if (e_ready) begin
      m_lost = 0;
      if (dbg_lock) begin
        m_locked = 1;
        m_age = 1;
      end
    end else if (e_owner == 1 && dbg_valid && m_lost < MAX_WAIT) begin
      m_lost++;
    end
  endtask

  task automatic test_reset();
    set_idle();
    reset = 1'b1;
    #2 reset = 1'b0;
    #3;
    chk_cnt++; if (dbg_rvalid_o !== 1'b0) begin fail_cnt++; $display("FAIL reset_rvalid: got %b want 0", dbg_rvalid_o); end
    chk_cnt++; if (dbg_rdata_o !== 32'h0) begin fail_cnt++; $display("FAIL reset_rdata: got %h want 0", dbg_rdata_o); end
    chk_cnt++; if (dbg_ready_o !== 1'b0) begin fail_cnt++; $display("FAIL reset_ready: got %b want 0", dbg_ready_o); end
    chk_cnt++; if (core_stall_o !== 1'b0) begin fail_cnt++; $display("FAIL reset_stall: got %b want 0", core_stall_o); end
    chk_cnt++; if ({mem_re_o, mem_we_o} !== 2'b00) begin fail_cnt++; $display("FAIL reset_strobes: got %b want 00", {mem_re_o, mem_we_o}); end
    chk_cnt++; if (mem_addr_o !== 32'h0) begin fail_cnt++; $display("FAIL reset_addr: got %h want 0", mem_addr_o); end
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_core_load();
    mem[4] = 32'hDEADBEEF;
    core_re = 1; core_addr = 32'h10;
    @(negedge clk);
    chk_cnt++; if (core_rdata_o !== 32'hDEADBEEF) begin fail_cnt++; $display("FAIL core_load_data: got %h want deadbeef", core_rdata_o); end
    chk_cnt++; if (core_stall_o !== 1'b0) begin fail_cnt++; $display("FAIL core_load_stall: got %b want 0", core_stall_o); end
    chk_cnt++; if (mem_re_o !== 1'b1 || mem_addr_o !== 32'h10) begin fail_cnt++; $display("FAIL core_load_mem: got re=%b addr=%h want re=1 addr=10", mem_re_o, mem_addr_o); end
    @(posedge clk); #1; set_idle();
  endtask

  task automatic test_dbg_read();
    mem[8] = 32'h12345678;
    dbg_valid = 1; dbg_we = 0; dbg_addr = 32'h20;
    @(negedge clk);
    chk_cnt++; if (dbg_ready_o !== 1'b1) begin fail_cnt++; $display("FAIL dbg_read_ready: got %b want 1", dbg_ready_o); end
    chk_cnt++; if (dbg_rvalid_o !== 1'b0) begin fail_cnt++; $display("FAIL dbg_read_rvalid_early: got %b want 0", dbg_rvalid_o); end
    @(posedge clk); #1; set_idle();
    @(negedge clk);
    chk_cnt++; if (dbg_rvalid_o !== 1'b1) begin fail_cnt++; $display("FAIL dbg_read_rvalid: got %b want 1", dbg_rvalid_o); end
    chk_cnt++; if (dbg_rdata_o !== 32'h12345678) begin fail_cnt++; $display("FAIL dbg_read_data: got %h want 12345678", dbg_rdata_o); end
    @(posedge clk); #1;
    @(negedge clk);
    chk_cnt++; if (dbg_rvalid_o !== 1'b0) begin fail_cnt++; $display("FAIL dbg_read_pulse: got %b want 0", dbg_rvalid_o); end
    chk_cnt++; if (dbg_rdata_o !== 32'h12345678) begin fail_cnt++; $display("FAIL dbg_read_hold: got %h want 12345678", dbg_rdata_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_starvation();
    int stalls = 0;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      core_re = 1; core_addr = 32'h30;
      dbg_valid = (cyc <= 5); dbg_we = 0; dbg_addr = 32'h40;
      @(negedge clk);
      if (core_stall_o === 1'b1) stalls++;
      chk_cnt++; if (dbg_ready_o !== (cyc == 5)) begin fail_cnt++; $display("FAIL starve_ready cyc%0d: got %b want %b", cyc, dbg_ready_o, cyc == 5); end
      chk_cnt++; if (core_stall_o !== (cyc == 5)) begin fail_cnt++; $display("FAIL starve_stall cyc%0d: got %b want %b", cyc, core_stall_o, cyc == 5); end
      @(posedge clk); #1;
    end
    chk_cnt++; if (stalls != 1) begin fail_cnt++; $display("FAIL starve_stall_count: got %0d want 1", stalls); end
    set_idle();
  endtask

  task automatic test_lock_burst();
    dbg_valid = 1; dbg_we = 1; dbg_lock = 1; dbg_addr = 32'h100; dbg_wdata = 32'hA000_0000;
    @(negedge clk);
    chk_cnt++; if (dbg_ready_o !== 1'b1 || mem_we_o !== 1'b1) begin fail_cnt++; $display("FAIL lock_entry: got ready=%b we=%b want 1 1", dbg_ready_o, mem_we_o); end
    for (int k = 1; k <= LOCK_MAX; k++) begin
      @(posedge clk); #1;
      core_re = 1; core_addr = 32'h30;
      dbg_valid = (k <= 2); dbg_addr = 32'h100 + 4 * k; dbg_wdata = 32'hA000_0000 + k;
      @(negedge clk);
      chk_cnt++; if (core_stall_o !== 1'b1) begin fail_cnt++; $display("FAIL lock_stall k%0d: got %b want 1", k, core_stall_o); end
      chk_cnt++; if (dbg_ready_o !== (k <= 2)) begin fail_cnt++; $display("FAIL lock_ready k%0d: got %b want %b", k, dbg_ready_o, k <= 2); end
    end
    @(posedge clk); #1;
    dbg_valid = 1; dbg_we = 0; dbg_lock = 0; dbg_addr = 32'h100;
    @(negedge clk);
    chk_cnt++; if (core_stall_o !== 1'b0 || dbg_ready_o !== 1'b0) begin fail_cnt++; $display("FAIL release_owner: got stall=%b ready=%b want 0 0", core_stall_o, dbg_ready_o); end
    chk_cnt++; if (mem_addr_o !== 32'h30 || mem_re_o !== 1'b1) begin fail_cnt++; $display("FAIL release_mem: got addr=%h re=%b want 30 1", mem_addr_o, mem_re_o); end
    @(posedge clk); #1;
    core_re = 0;
    @(negedge clk);
    chk_cnt++; if (dbg_ready_o !== 1'b1) begin fail_cnt++; $display("FAIL after_release_ready: got %b want 1", dbg_ready_o); end
    @(posedge clk); #1; set_idle();
    @(negedge clk);
    chk_cnt++; if (dbg_rdata_o !== 32'hA000_0000) begin fail_cnt++; $display("FAIL burst_word0: got %h want a0000000", dbg_rdata_o); end
    chk_cnt++; if (mem[65] !== 32'hA000_0001 || mem[66] !== 32'hA000_0002) begin fail_cnt++; $display("FAIL burst_words12: got %h %h want a0000001 a0000002", mem[65], mem[66]); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_lock();
    dbg_valid = 1; dbg_we = 0; dbg_lock = 1; dbg_addr = 32'h20;
    @(posedge clk); #1;
    core_re = 1; core_addr = 32'h30; dbg_addr = 32'h24;
    @(negedge clk);
    chk_cnt++; if (dbg_ready_o !== 1'b1 || core_stall_o !== 1'b1) begin fail_cnt++; $display("FAIL midlock_pre: got ready=%b stall=%b want 1 1", dbg_ready_o, core_stall_o); end
    #1 reset = 1'b0; dbg_lock = 0;
    #1;
    chk_cnt++; if (dbg_rvalid_o !== 1'b0 || dbg_rdata_o !== 32'h0) begin fail_cnt++; $display("FAIL midlock_rd: got rvalid=%b rdata=%h want 0 0", dbg_rvalid_o, dbg_rdata_o); end
    chk_cnt++; if (core_stall_o !== 1'b0 || dbg_ready_o !== 1'b0) begin fail_cnt++; $display("FAIL midlock_shared: got stall=%b ready=%b want 0 0", core_stall_o, dbg_ready_o); end
    @(posedge clk); #1;
    chk_cnt++; if (dbg_rvalid_o !== 1'b0) begin fail_cnt++; $display("FAIL midlock_rvalid_dropped: got %b want 0", dbg_rvalid_o); end
`ifdef DMARB_STATS_EN
    chk_cnt++; if (stat_stall_cnt_o !== 32'h0 || stat_dbg_cnt_o !== 32'h0) begin fail_cnt++; $display("FAIL midlock_stats: got %0d %0d want 0 0", stat_stall_cnt_o, stat_dbg_cnt_o); end
`endif
    set_idle();
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    for (int cyc = 1; cyc <= 5; cyc++) begin
      core_re = 1; core_addr = 32'h30; dbg_valid = 1; dbg_addr = 32'h20;
      @(negedge clk);
      chk_cnt++; if (dbg_ready_o !== (cyc == 5)) begin fail_cnt++; $display("FAIL postreset_wait cyc%0d: got %b want %b", cyc, dbg_ready_o, cyc == 5); end
      @(posedge clk); #1;
    end
    set_idle();
  endtask

  task automatic test_random();
    bit pend = 0;
    bit lock_want = 0;
    set_idle();
    reset = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); reset = 1'b1;
    model_reset();
    @(posedge clk); #1;
    for (int n = 0; n < 3000; n++) begin
      core_re = $urandom_range(0, 1); core_we = ($urandom_range(0, 3) == 0);
      core_addr = $urandom & 32'h3FC; core_wdata = $urandom;
      if (!pend) begin
        dbg_valid = ($urandom_range(0, 2) == 0); dbg_we = $urandom_range(0, 1);
        dbg_addr = $urandom & 32'h3FC; dbg_wdata = $urandom;
        if (lock_want ? ($urandom_range(0, 23) == 0) : ($urandom_range(0, 5) == 0)) lock_want = !lock_want;
        dbg_lock = lock_want;
      end
      @(negedge clk);
      model_eval();
      chk_cnt++; if (dbg_ready_o !== e_ready) begin fail_cnt++; $display("FAIL rnd_ready n%0d: got %b want %b", n, dbg_ready_o, e_ready); end
      chk_cnt++; if (core_stall_o !== e_stall) begin fail_cnt++; $display("FAIL rnd_stall n%0d: got %b want %b", n, core_stall_o, e_stall); end
      chk_cnt++; if ({mem_re_o, mem_we_o} !== {e_re, e_we}) begin fail_cnt++; $display("FAIL rnd_strobes n%0d: got %b want %b", n, {mem_re_o, mem_we_o}, {e_re, e_we}); end
      chk_cnt++; if (mem_addr_o !== e_addr || mem_wdata_o !== e_wdata) begin fail_cnt++; $display("FAIL rnd_mem n%0d: got %h/%h want %h/%h", n, mem_addr_o, mem_wdata_o, e_addr, e_wdata); end
      chk_cnt++; if (core_rdata_o !== e_core_rdata) begin fail_cnt++; $display("FAIL rnd_core_rdata n%0d: got %h want %h", n, core_rdata_o, e_core_rdata); end
      chk_cnt++; if (dbg_rvalid_o !== m_rvalid || dbg_rdata_o !== m_rdata) begin fail_cnt++; $display("FAIL rnd_rd n%0d: got %b/%h want %b/%h", n, dbg_rvalid_o, dbg_rdata_o, m_rvalid, m_rdata); end
      chk_cnt++; if ((mem_re_o & mem_we_o) !== 1'b0) begin fail_cnt++; $display("FAIL rnd_both_strobes n%0d: got re=%b we=%b", n, mem_re_o, mem_we_o); end
      pend = dbg_valid && !e_ready;
      @(posedge clk);
      model_advance();
      #1;
    end
    set_idle();
`ifdef DMARB_STATS_EN
    @(negedge clk);
    chk_cnt++; if (stat_stall_cnt_o !== m_stall_cnt) begin fail_cnt++; $display("FAIL stat_stall: got %0d want %0d", stat_stall_cnt_o, m_stall_cnt); end
    chk_cnt++; if (stat_dbg_cnt_o !== m_dbg_cnt) begin fail_cnt++; $display("FAIL stat_dbg: got %0d want %0d", stat_dbg_cnt_o, m_dbg_cnt); end
    @(posedge clk); #1;
`endif
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    test_reset();
    test_core_load();
    test_dbg_read();
    test_starvation();
    test_lock_burst();
    test_reset_mid_lock();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", chk_cnt, fail_cnt);
    $finish;
  end

endmodule
